// File: rtl/control_unit_pipe.sv
// control_unit_pipe: ID-stage control decoder with a registered ID/EX control
// word (stall/flush aware) and a small FSM that holds the front end busy while
// a MULT/DIV occupies the execute unit.
//
// Build option: define CU_ILLEGAL_TRAP_EN to make an illegal encoding trap the
// block. When it is defined, illegal becomes sticky and busy stays high, and
// only bubbles are issued until reset. Without the macro, illegal pulses for
// one cycle and decoding carries on.
module control_unit_pipe #(
  parameter int OPCODE_W      = 6,
  parameter int FUNCT_W       = 6,
  parameter int ALU_OP_W      = 4,
  parameter int MULDIV_CYCLES = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic                valid_in,
  input  logic [OPCODE_W-1:0] op_code,
  input  logic [FUNCT_W-1:0]  funct,
  input  logic                stall,
  input  logic                flush,
  output logic                valid_out,
  output logic                branch,
  output logic                is_beq,
  output logic                reg_dest,
  output logic                alu_src,
  output logic                mem_read,
  output logic                mem_write,
  output logic                mem_to_reg,
  output logic                reg_write,
  output logic                jump,
  output logic                jump_reg,
  output logic                muldiv,
  output logic [1:0]          mem_size,
  output logic                mem_unsigned,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                busy,
  output logic                illegal
);

  localparam int CNT_W = 8;

  // Opcodes
  localparam logic [OPCODE_W-1:0] OP_RTYPE = OPCODE_W'(6'b000000);
  localparam logic [OPCODE_W-1:0] OP_J     = OPCODE_W'(6'b000010);
  localparam logic [OPCODE_W-1:0] OP_JAL   = OPCODE_W'(6'b000011);
  localparam logic [OPCODE_W-1:0] OP_BEQ   = OPCODE_W'(6'b000100);
  localparam logic [OPCODE_W-1:0] OP_BNE   = OPCODE_W'(6'b000101);
  localparam logic [OPCODE_W-1:0] OP_ADDI  = OPCODE_W'(6'b001000);
  localparam logic [OPCODE_W-1:0] OP_ADDIU = OPCODE_W'(6'b001001);
  localparam logic [OPCODE_W-1:0] OP_SLTI  = OPCODE_W'(6'b001010);
  localparam logic [OPCODE_W-1:0] OP_SLTIU = OPCODE_W'(6'b001011);
  localparam logic [OPCODE_W-1:0] OP_ANDI  = OPCODE_W'(6'b001100);
  localparam logic [OPCODE_W-1:0] OP_ORI   = OPCODE_W'(6'b001101);
  localparam logic [OPCODE_W-1:0] OP_XORI  = OPCODE_W'(6'b001110);
  localparam logic [OPCODE_W-1:0] OP_LUI   = OPCODE_W'(6'b001111);
  localparam logic [OPCODE_W-1:0] OP_LB    = OPCODE_W'(6'b100000);
  localparam logic [OPCODE_W-1:0] OP_LH    = OPCODE_W'(6'b100001);
  localparam logic [OPCODE_W-1:0] OP_LW    = OPCODE_W'(6'b100011);
  localparam logic [OPCODE_W-1:0] OP_LBU   = OPCODE_W'(6'b100100);
  localparam logic [OPCODE_W-1:0] OP_LHU   = OPCODE_W'(6'b100101);
  localparam logic [OPCODE_W-1:0] OP_LWU   = OPCODE_W'(6'b100111);
  localparam logic [OPCODE_W-1:0] OP_SB    = OPCODE_W'(6'b101000);
  localparam logic [OPCODE_W-1:0] OP_SH    = OPCODE_W'(6'b101001);
  localparam logic [OPCODE_W-1:0] OP_SW    = OPCODE_W'(6'b101011);

  // R-type funct values
  localparam logic [FUNCT_W-1:0] FN_SLL   = FUNCT_W'(6'b000000);
  localparam logic [FUNCT_W-1:0] FN_SRL   = FUNCT_W'(6'b000010);
  localparam logic [FUNCT_W-1:0] FN_SRA   = FUNCT_W'(6'b000011);
  localparam logic [FUNCT_W-1:0] FN_SLLV  = FUNCT_W'(6'b000100);
  localparam logic [FUNCT_W-1:0] FN_SRLV  = FUNCT_W'(6'b000110);
  localparam logic [FUNCT_W-1:0] FN_SRAV  = FUNCT_W'(6'b000111);
  localparam logic [FUNCT_W-1:0] FN_JR    = FUNCT_W'(6'b001000);
  localparam logic [FUNCT_W-1:0] FN_JALR  = FUNCT_W'(6'b001001);
  localparam logic [FUNCT_W-1:0] FN_MFHI  = FUNCT_W'(6'b010000);
  localparam logic [FUNCT_W-1:0] FN_MFLO  = FUNCT_W'(6'b010010);
  localparam logic [FUNCT_W-1:0] FN_MULT  = FUNCT_W'(6'b011000);
  localparam logic [FUNCT_W-1:0] FN_MULTU = FUNCT_W'(6'b011001);
  localparam logic [FUNCT_W-1:0] FN_DIV   = FUNCT_W'(6'b011010);
  localparam logic [FUNCT_W-1:0] FN_DIVU  = FUNCT_W'(6'b011011);
  localparam logic [FUNCT_W-1:0] FN_ADD   = FUNCT_W'(6'b100000);
  localparam logic [FUNCT_W-1:0] FN_ADDU  = FUNCT_W'(6'b100001);
  localparam logic [FUNCT_W-1:0] FN_SUB   = FUNCT_W'(6'b100010);
  localparam logic [FUNCT_W-1:0] FN_SUBU  = FUNCT_W'(6'b100011);
  localparam logic [FUNCT_W-1:0] FN_AND   = FUNCT_W'(6'b100100);
  localparam logic [FUNCT_W-1:0] FN_OR    = FUNCT_W'(6'b100101);
  localparam logic [FUNCT_W-1:0] FN_XOR   = FUNCT_W'(6'b100110);
  localparam logic [FUNCT_W-1:0] FN_NOR   = FUNCT_W'(6'b100111);
  localparam logic [FUNCT_W-1:0] FN_SLT   = FUNCT_W'(6'b101010);
  localparam logic [FUNCT_W-1:0] FN_SLTU  = FUNCT_W'(6'b101011);

  typedef struct packed {
    logic                valid;
    logic                branch;
    logic                is_beq;
    logic                reg_dest;
    logic                alu_src;
    logic                mem_read;
    logic                mem_write;
    logic                mem_to_reg;
    logic                reg_write;
    logic                jump;
    logic                jump_reg;
    logic                muldiv;
    logic [1:0]          mem_size;
    logic                mem_unsigned;
    logic [ALU_OP_W-1:0] alu_op;
  } ctrl_t;

  typedef enum logic {IDLE, MULDIV} state_t;

  ctrl_t             dec_p0;
  logic              dec_legal_p0;
  logic [3:0]        dec_alu_p0;
  logic [1:0]        ls_size_p0;
  logic              accept_p0;
  logic              trap;
  ctrl_t             cw_p1;
  logic              illegal_p1;
  state_t            state;
  logic [CNT_W-1:0]  cnt;

  // Byte/half/word size straight from the low opcode bits (x11 means word).
  assign ls_size_p0 = (op_code[1:0] == 2'b11) ? 2'b10 : op_code[1:0];

  // Combinational decode of opcode/funct into a candidate control word.
  always_comb begin
    dec_p0       = '0;
    dec_legal_p0 = 1'b0;
    dec_alu_p0   = 4'b0000;
    case (op_code)
      OP_RTYPE: begin
        dec_p0.reg_dest  = 1'b1;
        dec_p0.reg_write = 1'b1;
        dec_alu_p0       = 4'b0000;
        case (funct)
          FN_JR: begin
            dec_legal_p0     = 1'b1;
            dec_p0.jump_reg  = 1'b1;
            dec_p0.reg_write = 1'b0;
          end
          FN_JALR: begin
            dec_legal_p0    = 1'b1;
            dec_p0.jump_reg = 1'b1;
          end
          FN_MULT, FN_MULTU, FN_DIV, FN_DIVU: begin
            dec_legal_p0     = 1'b1;
            dec_p0.muldiv    = 1'b1;
            dec_p0.reg_write = 1'b0;
          end
          FN_SLL, FN_SRL, FN_SRA, FN_SLLV, FN_SRLV, FN_SRAV,
          FN_MFHI, FN_MFLO,
          FN_ADD, FN_ADDU, FN_SUB, FN_SUBU,
          FN_AND, FN_OR, FN_XOR, FN_NOR, FN_SLT, FN_SLTU: begin
            dec_legal_p0 = 1'b1;
          end
          default: dec_legal_p0 = 1'b0;
        endcase
      end
      OP_BEQ: begin
        dec_legal_p0  = 1'b1;
        dec_p0.branch = 1'b1;
        dec_p0.is_beq = 1'b1;
        dec_alu_p0    = 4'b0001;
      end
      OP_BNE: begin
        dec_legal_p0  = 1'b1;
        dec_p0.branch = 1'b1;
        dec_alu_p0    = 4'b0011;
      end
      OP_J: begin
        dec_legal_p0 = 1'b1;
        dec_p0.jump  = 1'b1;
        dec_alu_p0   = 4'b0100;
      end
      OP_JAL: begin
        dec_legal_p0     = 1'b1;
        dec_p0.jump      = 1'b1;
        dec_p0.reg_write = 1'b1;
        dec_p0.reg_dest  = 1'b1;
        dec_alu_p0       = 4'b0101;
      end
      OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_LWU: begin
        dec_legal_p0        = 1'b1;
        dec_p0.alu_src      = 1'b1;
        dec_p0.mem_read     = 1'b1;
        dec_p0.mem_to_reg   = 1'b1;
        dec_p0.reg_write    = 1'b1;
        dec_p0.mem_size     = ls_size_p0;
        dec_p0.mem_unsigned = op_code[2];
        dec_alu_p0          = 4'b0110;
      end
      OP_SB, OP_SH, OP_SW: begin
        dec_legal_p0     = 1'b1;
        dec_p0.alu_src   = 1'b1;
        dec_p0.mem_write = 1'b1;
        dec_p0.mem_size  = ls_size_p0;
        dec_alu_p0       = 4'b0111;
      end
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
      OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
        dec_legal_p0     = 1'b1;
        dec_p0.alu_src   = 1'b1;
        dec_p0.reg_write = 1'b1;
        case (op_code)
          OP_ADDI:  dec_alu_p0 = 4'b1000;
          OP_ADDIU: dec_alu_p0 = 4'b1001;
          OP_ANDI:  dec_alu_p0 = 4'b1010;
          OP_ORI:   dec_alu_p0 = 4'b1011;
          OP_XORI:  dec_alu_p0 = 4'b1100;
          OP_LUI:   dec_alu_p0 = 4'b1101;
          OP_SLTI:  dec_alu_p0 = 4'b1110;
          default:  dec_alu_p0 = 4'b1111;
        endcase
      end
      default: dec_legal_p0 = 1'b0;
    endcase
    dec_p0.valid  = dec_legal_p0;
    dec_p0.alu_op = ALU_OP_W'(dec_alu_p0);
  end

`ifdef CU_ILLEGAL_TRAP_EN
  // Once trapped, the sticky illegal flag blocks every further accept.
  assign trap = illegal_p1;
`else
  assign trap = 1'b0;
`endif

  // An instruction is taken only when the register is free to load and the
  // execute unit is not occupied by a MULT/DIV.
  assign accept_p0 = valid_in & enable & ~flush & ~stall & (state == IDLE) & ~trap;

  // ---- ID/EX boundary ----
  // ID/EX control register: flush beats stall beats load; illegal loads bubble.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cw_p1 <= '0;
    end else if (flush) begin
      cw_p1 <= '0;
    end else if (!stall) begin
      if (accept_p0 && dec_legal_p0) begin
        cw_p1 <= dec_p0;
      end else begin
        cw_p1 <= '0;
      end
    end
  end

  // Illegal-encoding flag: one-cycle pulse per illegal load, or sticky when trapping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      illegal_p1 <= 1'b0;
    end else begin
`ifdef CU_ILLEGAL_TRAP_EN
      if (accept_p0 && !dec_legal_p0) begin
        illegal_p1 <= 1'b1;
      end
`else
      illegal_p1 <= accept_p0 & ~dec_legal_p0;
`endif
    end
  end

  // MULT/DIV occupancy FSM. Leaving MULDIV happens at the edge where the
  // counter reaches zero, so busy drops in that same cycle; a counter already
  // at zero (single-cycle occupancy) still yields one busy cycle. Flush does
  // not cancel an issued MULT/DIV; stall freezes the count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept_p0 && dec_legal_p0 && dec_p0.muldiv) begin
            state <= MULDIV;
            cnt   <= CNT_W'(MULDIV_CYCLES - 1);
          end
        end
        default: begin
          if (!stall) begin
            if (cnt <= CNT_W'(1)) begin
              state <= IDLE;
              cnt   <= '0;
            end else begin
              cnt <= cnt - CNT_W'(1);
            end
          end
        end
      endcase
    end
  end

  assign busy         = (state == MULDIV) | trap;
  assign illegal      = illegal_p1;
  assign valid_out    = cw_p1.valid;
  assign branch       = cw_p1.branch;
  assign is_beq       = cw_p1.is_beq;
  assign reg_dest     = cw_p1.reg_dest;
  assign alu_src      = cw_p1.alu_src;
  assign mem_read     = cw_p1.mem_read;
  assign mem_write    = cw_p1.mem_write;
  assign mem_to_reg   = cw_p1.mem_to_reg;
  assign reg_write    = cw_p1.reg_write;
  assign jump         = cw_p1.jump;
  assign jump_reg     = cw_p1.jump_reg;
  assign muldiv       = cw_p1.muldiv;
  assign mem_size     = cw_p1.mem_size;
  assign mem_unsigned = cw_p1.mem_unsigned;
  assign alu_op       = cw_p1.alu_op;

endmodule

// File: tb/tb_control_unit_pipe.sv
// Testbench for control_unit_pipe: table of single-cycle decode vectors plus
// hand-written sequences for MULT/DIV occupancy, async reset and illegal ops.
module tb_control_unit_pipe;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic       valid_in;
  logic [5:0] op_code;
  logic [5:0] funct;
  logic       stall;
  logic       flush;
  logic       valid_out, branch, is_beq, reg_dest, alu_src, mem_read, mem_write;
  logic       mem_to_reg, reg_write, jump, jump_reg, muldiv;
  logic [1:0] mem_size;
  logic       mem_unsigned;
  logic [3:0] alu_op;
  logic       busy;
  logic       illegal;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  control_unit_pipe #(
    .OPCODE_W(6), .FUNCT_W(6), .ALU_OP_W(4), .MULDIV_CYCLES(4)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .valid_in(valid_in),
    .op_code(op_code), .funct(funct), .stall(stall), .flush(flush),
    .valid_out(valid_out), .branch(branch), .is_beq(is_beq), .reg_dest(reg_dest),
    .alu_src(alu_src), .mem_read(mem_read), .mem_write(mem_write),
    .mem_to_reg(mem_to_reg), .reg_write(reg_write), .jump(jump),
    .jump_reg(jump_reg), .muldiv(muldiv), .mem_size(mem_size),
    .mem_unsigned(mem_unsigned), .alu_op(alu_op), .busy(busy), .illegal(illegal)
  );

  typedef struct {
    logic        vin;
    logic        en;
    logic [5:0]  op;
    logic [5:0]  fn;
    logic        st;
    logic        fl;
    logic [19:0] exp;
  } vec_t;

  vec_t tbl[$];

  // flags bit order: valid branch is_beq reg_dest alu_src mem_read mem_write
  //                  mem_to_reg reg_write jump jump_reg muldiv
  function automatic logic [19:0] w(input logic [11:0] flags, input logic [1:0] sz,
                                    input logic us, input logic [3:0] alu, input logic il);
    return {flags, sz, us, alu, il};
  endfunction

  function automatic logic [19:0] word();
    return {valid_out, branch, is_beq, reg_dest, alu_src, mem_read, mem_write,
            mem_to_reg, reg_write, jump, jump_reg, muldiv,
            mem_size, mem_unsigned, alu_op, illegal};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic vin, input logic en, input logic [5:0] op,
                       input logic [5:0] fn, input logic st, input logic fl);
    valid_in = vin; enable = en; op_code = op; funct = fn; stall = st; flush = fl;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic vin, input logic en, input logic [5:0] op,
                     input logic [5:0] fn, input logic st, input logic fl,
                     input logic [19:0] e);
    vec_t v;
    v.vin = vin; v.en = en; v.op = op; v.fn = fn; v.st = st; v.fl = fl; v.exp = e;
    tbl.push_back(v);
  endtask

  localparam logic [11:0] F_LD   = 12'b1000_1101_1000;
  localparam logic [11:0] F_ST   = 12'b1000_1010_0000;
  localparam logic [11:0] F_R    = 12'b1001_0000_1000;
  localparam logic [11:0] F_BEQ  = 12'b1110_0000_0000;
  localparam logic [11:0] F_BNE  = 12'b1100_0000_0000;
  localparam logic [11:0] F_J    = 12'b1000_0000_0100;
  localparam logic [11:0] F_JAL  = 12'b1001_0000_1100;
  localparam logic [11:0] F_IALU = 12'b1000_1000_1000;
  localparam logic [11:0] F_JR   = 12'b1001_0000_0010;
  localparam logic [11:0] F_JALR = 12'b1001_0000_1010;
  localparam logic [11:0] F_DIV  = 12'b1001_0000_0001;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [19:0] div_w;
    logic [19:0] addi_w;
    logic [19:0] ori_w;
    int n;
    div_w  = w(F_DIV, 2'b00, 1'b0, 4'b0000, 1'b0);
    addi_w = w(F_IALU, 2'b00, 1'b0, 4'b1000, 1'b0);
    ori_w  = w(F_IALU, 2'b00, 1'b0, 4'b1011, 1'b0);

    add(1'b1, 1'b1, 6'b100011, 6'b0, 1'b0, 1'b0, w(F_LD, 2'b10, 1'b0, 4'b0110, 1'b0)); // LW
    add(1'b1, 1'b1, 6'b100101, 6'b0, 1'b0, 1'b0, w(F_LD, 2'b01, 1'b1, 4'b0110, 1'b0)); // LHU
    add(1'b1, 1'b1, 6'b101000, 6'b0, 1'b0, 1'b0, w(F_ST, 2'b00, 1'b0, 4'b0111, 1'b0)); // SB
    add(1'b1, 1'b1, 6'b000000, 6'b100000, 1'b0, 1'b0, w(F_R, 2'b00, 1'b0, 4'b0000, 1'b0)); // ADD
    add(1'b1, 1'b1, 6'b000100, 6'b0, 1'b0, 1'b0, w(F_BEQ, 2'b00, 1'b0, 4'b0001, 1'b0));
    add(1'b1, 1'b1, 6'b000101, 6'b0, 1'b0, 1'b0, w(F_BNE, 2'b00, 1'b0, 4'b0011, 1'b0));
    add(1'b1, 1'b1, 6'b000010, 6'b0, 1'b0, 1'b0, w(F_J, 2'b00, 1'b0, 4'b0100, 1'b0));
    add(1'b1, 1'b1, 6'b000011, 6'b0, 1'b0, 1'b0, w(F_JAL, 2'b00, 1'b0, 4'b0101, 1'b0));
    add(1'b1, 1'b1, 6'b001000, 6'b0, 1'b0, 1'b0, addi_w);                                // ADDI
    add(1'b1, 1'b1, 6'b001001, 6'b0, 1'b0, 1'b0, w(F_IALU, 2'b00, 1'b0, 4'b1001, 1'b0)); // ADDIU
    add(1'b1, 1'b1, 6'b001010, 6'b0, 1'b0, 1'b0, w(F_IALU, 2'b00, 1'b0, 4'b1110, 1'b0)); // SLTI
    add(1'b1, 1'b1, 6'b001011, 6'b0, 1'b0, 1'b0, w(F_IALU, 2'b00, 1'b0, 4'b1111, 1'b0)); // SLTIU
    add(1'b1, 1'b1, 6'b001100, 6'b0, 1'b0, 1'b0, w(F_IALU, 2'b00, 1'b0, 4'b1010, 1'b0)); // ANDI
    add(1'b1, 1'b1, 6'b001101, 6'b0, 1'b0, 1'b0, ori_w);                                 // ORI
    add(1'b1, 1'b1, 6'b001110, 6'b0, 1'b0, 1'b0, w(F_IALU, 2'b00, 1'b0, 4'b1100, 1'b0)); // XORI
    add(1'b1, 1'b1, 6'b001111, 6'b0, 1'b0, 1'b0, w(F_IALU, 2'b00, 1'b0, 4'b1101, 1'b0)); // LUI
    add(1'b1, 1'b1, 6'b000000, 6'b001000, 1'b0, 1'b0, w(F_JR, 2'b00, 1'b0, 4'b0000, 1'b0));
    add(1'b1, 1'b1, 6'b000000, 6'b001001, 1'b0, 1'b0, w(F_JALR, 2'b00, 1'b0, 4'b0000, 1'b0));
    add(1'b1, 1'b1, 6'b100000, 6'b0, 1'b0, 1'b0, w(F_LD, 2'b00, 1'b0, 4'b0110, 1'b0)); // LB
    add(1'b1, 1'b1, 6'b100001, 6'b0, 1'b0, 1'b0, w(F_LD, 2'b01, 1'b0, 4'b0110, 1'b0)); // LH
    add(1'b1, 1'b1, 6'b100100, 6'b0, 1'b0, 1'b0, w(F_LD, 2'b00, 1'b1, 4'b0110, 1'b0)); // LBU
    add(1'b1, 1'b1, 6'b100111, 6'b0, 1'b0, 1'b0, w(F_LD, 2'b10, 1'b1, 4'b0110, 1'b0)); // LWU
    add(1'b1, 1'b1, 6'b101001, 6'b0, 1'b0, 1'b0, w(F_ST, 2'b01, 1'b0, 4'b0111, 1'b0)); // SH
    add(1'b1, 1'b1, 6'b101011, 6'b0, 1'b0, 1'b0, w(F_ST, 2'b10, 1'b0, 4'b0111, 1'b0)); // SW
    add(1'b0, 1'b1, 6'b001000, 6'b0, 1'b0, 1'b0, 20'h0);   // valid_in low -> bubble
    add(1'b1, 1'b0, 6'b001000, 6'b0, 1'b0, 1'b0, 20'h0);   // enable low -> bubble
    add(1'b1, 1'b1, 6'b001000, 6'b0, 1'b0, 1'b0, addi_w);  // ADDI loads
    add(1'b1, 1'b1, 6'b001101, 6'b0, 1'b1, 1'b0, addi_w);  // stall holds ADDI
    add(1'b1, 1'b1, 6'b001101, 6'b0, 1'b1, 1'b1, 20'h0);   // stall+flush -> bubble
    add(1'b1, 1'b1, 6'b001000, 6'b0, 1'b0, 1'b0, addi_w);  // ADDI loads again
    add(1'b1, 1'b1, 6'b001000, 6'b0, 1'b1, 1'b1, 20'h0);   // ADDI under stall+flush
    add(1'b1, 1'b1, 6'b100011, 6'b0, 1'b0, 1'b1, 20'h0);   // flush only

    // Reset state
    reset = 1'b1;
    drive(1'b0, 1'b0, 6'b0, 6'b0, 1'b0, 1'b0);
    #12;
    chk("reset_word", 32'(word()), 32'h0);
    chk("reset_busy", 32'(busy), 32'h0);
    @(negedge clk);
    reset = 1'b0;

    // Table of single-cycle decode vectors
    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].vin, tbl[i].en, tbl[i].op, tbl[i].fn, tbl[i].st, tbl[i].fl);
      step();
      chk($sformatf("vec%0d", i), 32'(word()), 32'(tbl[i].exp));
      chk($sformatf("vec%0d_busy", i), 32'(busy), 32'h0);
    end

    // DIV, no stall: busy for 3 cycles, valid_in ignored meanwhile
    drive(1'b1, 1'b1, 6'b000000, 6'b011010, 1'b0, 1'b0);
    step();
    chk("div_word", 32'(word()), 32'(div_w));
    chk("div_busy0", 32'(busy), 32'h1);
    drive(1'b1, 1'b1, 6'b001000, 6'b0, 1'b0, 1'b0);
    n = 1;
    for (int k = 0; k < 20; k++) begin
      step();
      if (!busy) break;
      n++;
      chk($sformatf("div_bubble%0d", k), 32'(word()), 32'h0);
    end
    chk("div_busy_cycles", 32'(n), 32'd3);
    chk("div_drop_bubble", 32'(valid_out), 32'h0);
    step();
    chk("after_div_addi", 32'(word()), 32'(addi_w));

    // DIV with one stall cycle: busy for 4 cycles, word held during the stall
    drive(1'b1, 1'b1, 6'b000000, 6'b011010, 1'b0, 1'b0);
    step();
    chk("div2_word", 32'(word()), 32'(div_w));
    drive(1'b1, 1'b1, 6'b001000, 6'b0, 1'b1, 1'b0);
    step();
    chk("div2_stall_hold", 32'(word()), 32'(div_w));
    n = busy ? 2 : 1;
    drive(1'b1, 1'b1, 6'b001000, 6'b0, 1'b0, 1'b0);
    for (int k = 0; k < 20; k++) begin
      step();
      if (!busy) break;
      n++;
    end
    chk("div2_busy_cycles", 32'(n), 32'd4);

    // Async reset in the middle of a MULT/DIV (counter at 2)
    drive(1'b0, 1'b0, 6'b0, 6'b0, 1'b0, 1'b0);
    step();
    drive(1'b1, 1'b1, 6'b000000, 6'b011010, 1'b0, 1'b0);
    step();
    drive(1'b0, 1'b0, 6'b0, 6'b0, 1'b0, 1'b0);
    step();
    chk("pre_reset_busy", 32'(busy), 32'h1);
    #3;
    reset = 1'b1;
    #1;
    chk("async_reset_word", 32'(word()), 32'h0);
    chk("async_reset_busy", 32'(busy), 32'h0);
    @(negedge clk);
    reset = 1'b0;

    // Illegal opcode followed by ORI
    drive(1'b1, 1'b1, 6'b111111, 6'b0, 1'b0, 1'b0);
    step();
    chk("illegal_set", 32'(illegal), 32'h1);
    chk("illegal_bubble", 32'(valid_out), 32'h0);
    drive(1'b1, 1'b1, 6'b001101, 6'b0, 1'b0, 1'b0);
    step();
`ifdef CU_ILLEGAL_TRAP_EN
    chk("trap_illegal", 32'(illegal), 32'h1);
    chk("trap_busy", 32'(busy), 32'h1);
    chk("trap_bubble", 32'(valid_out), 32'h0);
    step();
    step();
    chk("trap_still_illegal", 32'(illegal), 32'h1);
    chk("trap_still_busy", 32'(busy), 32'h1);
    reset = 1'b1;
    #1;
    chk("trap_reset_illegal", 32'(illegal), 32'h0);
    chk("trap_reset_busy", 32'(busy), 32'h0);
    @(negedge clk);
    reset = 1'b0;
`else
    chk("illegal_then_ori", 32'(word()), 32'(ori_w));
    chk("illegal_busy", 32'(busy), 32'h0);
    // Illegal R-type funct
    drive(1'b1, 1'b1, 6'b000000, 6'b111111, 1'b0, 1'b0);
    step();
    chk("illegal_funct", 32'(word()), 32'(w(12'h0, 2'b00, 1'b0, 4'b0000, 1'b1)));
    drive(1'b0, 1'b1, 6'b0, 6'b0, 1'b0, 1'b0);
    step();
    chk("illegal_pulse_end", 32'(illegal), 32'h0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
